alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 154 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction into registered ALU operands and an op code.
// Illegal encodings produce a one-cycle pulse and bump a saturating counter.
module alu_issue_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [4:0]           shamt_in,
  input  logic [15:0]          imm16,
  input  logic [31:0]          rs_data,
  input  logic [31:0]          rt_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 in_ready,
  output logic [31:0]          op1,
  output logic [31:0]          op2,
  output logic [4:0]           shamt,
  output logic [3:0]           ALUsignal,
  output logic                 out_valid,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_AND = 4'd1, ALU_NOR = 4'd2, ALU_OR  = 4'd3,
    ALU_SLT  = 4'd4, ALU_SLTU = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
    ALU_SUB  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic        legal;
    alu_op_e     alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } dec_t;

  dec_t        dec;
  logic [31:0] imm_sx, imm_zx;

  logic [31:0]          op1_q, op1_d, op2_q, op2_d;
  logic [4:0]           sh_q, sh_d;
  logic [3:0]           alu_q, alu_d;
  logic                 vld_q, vld_d;
  logic                 ill_q, ill_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

  assign imm_sx = {{16{imm16[15]}}, imm16};
  assign imm_zx = {16'h0000, imm16};

  always_comb begin
    dec       = '0;
    dec.legal = 1'b1;
    dec.alu   = ALU_ADD;
    dec.a     = rs_data;
    dec.b     = rt_data;
    dec.sh    = 5'd0;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h20, 6'h21: dec.alu = ALU_ADD;
          6'h22, 6'h23: dec.alu = ALU_SUB;
          6'h24:        dec.alu = ALU_AND;
          6'h25:        dec.alu = ALU_OR;
          6'h27:        dec.alu = ALU_NOR;
          6'h2A:        dec.alu = ALU_SLT;
          6'h2B:        dec.alu = ALU_SLTU;
          6'h00: begin  dec.alu = ALU_SLL; dec.sh = shamt_in; end
          6'h02: begin  dec.alu = ALU_SRL; dec.sh = shamt_in; end
          default:      dec.legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin dec.alu = ALU_ADD;  dec.b = imm_sx; end
      6'h0A:                      begin dec.alu = ALU_SLT;  dec.b = imm_sx; end
      6'h0B:                      begin dec.alu = ALU_SLTU; dec.b = imm_sx; end
      6'h0C:                      begin dec.alu = ALU_AND;  dec.b = imm_zx; end
      6'h0D:                      begin dec.alu = ALU_OR;   dec.b = imm_zx; end
      6'h04, 6'h05:               dec.alu = ALU_SUB;
      // lui is executed as (imm << 16) on the shifter
      6'h0F: begin
        dec.alu = ALU_SLL;
        dec.a   = 32'd0;
        dec.b   = imm_zx;
        dec.sh  = 5'd16;
      end
      default: dec.legal = 1'b0;
    endcase
  end

  // Priority: flush > stall > load; the illegal pulse only lives for one registered cycle.
  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    sh_d  = sh_q;
    alu_d = alu_q;
    vld_d = vld_q;
    ill_d = 1'b0;
    cnt_d = cnt_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        vld_d = 1'b0;
      end else if (dec.legal) begin
        op1_d = dec.a;
        op2_d = dec.b;
        sh_d  = dec.sh;
        alu_d = dec.alu;
        vld_d = 1'b1;
      end else begin
        op1_d = 32'd0;
        op2_d = 32'd0;
        sh_d  = 5'd0;
        alu_d = 4'd0;
        vld_d = 1'b0;
        ill_d = 1'b1;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + ILL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      sh_q  <= '0;
      alu_q <= '0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      sh_q  <= sh_d;
      alu_q <= alu_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = ~stall;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign shamt     = sh_q;
  assign ALUsignal = alu_q;
  assign out_valid = vld_q;
  assign illegal   = ill_q;
  assign ill_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic against a table-driven model.
module tb_alu_issue_stage;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, stall, flush;
  logic [5:0]    opcode, funct;
  logic [4:0]    shamt_in;
  logic [15:0]   imm16;
  logic [31:0]   rs_data, rt_data;
  logic          in_ready, out_valid, illegal;
  logic [31:0]   op1, op2;
  logic [4:0]    shamt;
  logic [3:0]    ALUsignal;
  logic [CW-1:0] ill_count;

  int n_chk = 0, n_pass = 0;

  // model state
  int unsigned m_op1, m_op2, m_sh, m_alu, m_vld, m_ill, m_cnt;

  alu_issue_stage #(.ILL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .shamt_in(shamt_in), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .flush(flush), .in_ready(in_ready), .op1(op1), .op2(op2),
    .shamt(shamt), .ALUsignal(ALUsignal), .out_valid(out_valid), .illegal(illegal),
    .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                  output bit ok, output int unsigned alu, output int unsigned a,
                                  output int unsigned b, output int unsigned s);
    int unsigned sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    ok = 1; alu = 0; a = rs; b = rt; s = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: alu = 0;
        6'h22, 6'h23: alu = 8;
        6'h24: alu = 1;
        6'h25: alu = 3;
        6'h27: alu = 2;
        6'h2A: alu = 4;
        6'h2B: alu = 5;
        6'h00: alu = 6;
        6'h02: alu = 7;
        default: ok = 0;
      endcase
      if (alu == 6 || alu == 7) s = sh;
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) begin alu = 0; b = sx; end
    else if (op == 6'h0A) begin alu = 4; b = sx; end
    else if (op == 6'h0B) begin alu = 5; b = sx; end
    else if (op == 6'h0C) begin alu = 1; b = zx; end
    else if (op == 6'h0D) begin alu = 3; b = zx; end
    else if (op == 6'h04 || op == 6'h05) alu = 8;
    else if (op == 6'h0F) begin alu = 6; a = 0; b = zx; s = 16; end
    else ok = 0;
  endfunction

  task automatic model_edge();
    bit ok;
    int unsigned alu, a, b, s;
    ref_dec(opcode, funct, shamt_in, imm16, rs_data, rt_data, ok, alu, a, b, s);
    m_ill = 0;
    if (!rst_n) begin
      m_op1 = 0; m_op2 = 0; m_sh = 0; m_alu = 0; m_vld = 0; m_cnt = 0;
    end else if (flush) m_vld = 0;
    else if (stall) ;
    else if (!in_valid) m_vld = 0;
    else if (ok) begin
      m_op1 = a; m_op2 = b; m_sh = s; m_alu = alu; m_vld = 1;
    end else begin
      m_op1 = 0; m_op2 = 0; m_sh = 0; m_alu = 0; m_vld = 0; m_ill = 1;
      if (m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op1"}, op1, m_op1);
    chk({tag, ".op2"}, op2, m_op2);
    chk({tag, ".shamt"}, {27'd0, shamt}, m_sh);
    chk({tag, ".alu"}, {28'd0, ALUsignal}, m_alu);
    chk({tag, ".vld"}, {31'd0, out_valid}, m_vld);
    chk({tag, ".ill"}, {31'd0, illegal}, m_ill);
    chk({tag, ".cnt"}, {24'd0, ill_count}, m_cnt);
  endtask

  // Inputs are set at negedge by the caller; this checks in_ready, clocks once and checks outputs.
  task automatic cyc(input string tag);
    #1 chk({tag, ".rdy"}, {31'd0, in_ready}, {31'd0, ~stall});
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic drive(input logic r, input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl);
    @(negedge clk);
    rst_n = r; in_valid = v; opcode = op; funct = fn; shamt_in = sh; imm16 = imm;
    rs_data = rs; rt_data = rt; stall = st; flush = fl;
  endtask

  logic [5:0] legal_ops [11] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h04, 6'h0F};
  logic [5:0] legal_fn [11]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};

  initial begin
    m_op1 = 0; m_op2 = 0; m_sh = 0; m_alu = 0; m_vld = 0; m_ill = 0; m_cnt = 0;
    // reset held 2 cycles with stall and a legal instruction present
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 6'h00, 6'h20, 5'd3, 16'h1, 32'd5, 32'd6, 1, 0);
      cyc("rst");
    end
    chk("rst.all_zero", {op1 | op2}, 32'd0);
    chk("rst.vld", {31'd0, out_valid}, 32'd0);

    // first edge out of reset loads: sub
    drive(1, 1, 6'h00, 6'h22, 5'd7, 16'h0, 32'd10, 32'd3, 0, 0);
    cyc("sub");
    chk("sub.alu8", {28'd0, ALUsignal}, 32'd8);
    chk("sub.op1", op1, 32'd10);
    chk("sub.op2", op2, 32'd3);
    chk("sub.vld", {31'd0, out_valid}, 32'd1);

    drive(1, 1, 6'h08, 6'h0, 5'd0, 16'hFFFE, 32'd1, 32'd2, 0, 0);
    cyc("addi");
    chk("addi.sext", op2, 32'hFFFF_FFFE);
    chk("addi.alu", {28'd0, ALUsignal}, 32'd0);
    drive(1, 1, 6'h0C, 6'h0, 5'd0, 16'hFFFE, 32'd1, 32'd2, 0, 0);
    cyc("andi");
    chk("andi.zext", op2, 32'h0000_FFFE);
    chk("andi.alu", {28'd0, ALUsignal}, 32'd1);
    drive(1, 1, 6'h0F, 6'h0, 5'd0, 16'h1234, 32'hDEAD, 32'd2, 0, 0);
    cyc("lui");
    chk("lui.alu", {28'd0, ALUsignal}, 32'd6);
    chk("lui.op1", op1, 32'd0);
    chk("lui.op2", op2, 32'h0000_1234);
    chk("lui.sh", {27'd0, shamt}, 32'd16);

    // legal load then 3 stalled cycles with changing inputs
    drive(1, 1, 6'h00, 6'h00, 5'd9, 16'h0, 32'h11, 32'h22, 0, 0);
    cyc("sll");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 6'($urandom), 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom, 1, 0);
      cyc("stall");
      chk("stall.sh", {27'd0, shamt}, 32'd9);
      chk("stall.op2", op2, 32'h22);
      chk("stall.rdy", {31'd0, in_ready}, 32'd0);
    end
    drive(1, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1, 1, 1);
    cyc("stfl");
    chk("stfl.vld", {31'd0, out_valid}, 32'd0);
    chk("stfl.op1", op1, 32'h11);
    // illegal under flush/stall must not count
    drive(1, 1, 6'h3F, 6'h0, 5'd0, 16'h0, 32'd1, 32'd1, 0, 1);
    cyc("illfl");
    drive(1, 1, 6'h3F, 6'h0, 5'd0, 16'h0, 32'd1, 32'd1, 1, 0);
    cyc("illst");
    chk("illst.cnt", {24'd0, ill_count}, 32'd0);

    // reset during stall discards the held instruction
    drive(1, 1, 6'h00, 6'h25, 5'd0, 16'h0, 32'h7, 32'h8, 0, 0);
    cyc("or");
    drive(0, 0, 6'h00, 6'h25, 5'd0, 16'h0, 32'h7, 32'h8, 1, 0);
    cyc("rstst");
    chk("rstst.op1", op1, 32'd0);

    // saturation run
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 6'h3F, 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom, 0, 0);
      cyc("sat");
    end
    chk("sat.cnt255", {24'd0, ill_count}, 32'd255);
    chk("sat.ill", {31'd0, illegal}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(9, 0) < 7) ? legal_ops[$urandom_range(10, 0)] : 6'($urandom);
      fn = ($urandom_range(9, 0) < 8) ? legal_fn[$urandom_range(10, 0)] : 6'($urandom);
      drive($urandom_range(49, 0) != 0, $urandom_range(9, 0) < 8, op, fn, 5'($urandom),
            16'($urandom), $urandom, $urandom, $urandom_range(9, 0) < 2, $urandom_range(9, 0) < 1);
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
